// File: rtl/util_cpack2_timestamp_insert.sv
// Buffers packed ADC blocks and inserts a 64-bit timestamp word ahead of every
// N-th block (and after any drop), for a DMA that accepts words with m_axis_ready.
module util_cpack2_timestamp_insert #(
    parameter int NUM_OF_CHANNELS     = 4,
    parameter int SAMPLES_PER_CHANNEL = 1,
    parameter int SAMPLE_DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH          = 8,
    localparam int DW = NUM_OF_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH
) (
    input  logic          adc_clk,
    input  logic          resetn,
    input  logic [63:0]   timestamp,
    input  logic [31:0]   timestamp_every,
    input  logic          s_axis_valid,
    input  logic [DW-1:0] s_axis_data,
    input  logic          m_axis_xfer_req,
    output logic          m_axis_valid,
    input  logic          m_axis_ready,
    output logic [DW-1:0] m_axis_data,
    output logic          overflow,
    output logic          fsm_state
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (DW < 64) begin : g_width_check
        $error("util_cpack2_timestamp_insert: block width must be at least 64 bits");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("util_cpack2_timestamp_insert: FIFO_DEPTH must be a power of 2 and >= 4");
    end

    typedef enum logic {
        EMIT_TS   = 1'b0,
        EMIT_DATA = 1'b1
    } out_state_t;

    out_state_t state_q, state_d;

    logic [DW-1:0]         mem_data [FIFO_DEPTH];
    logic [63:0]           mem_ts   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_flag;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   blk_cnt_q, blk_cnt_d;
    logic          full, head_flag, pop, accept, drop, entry_flag;

    // Valid/ready: a word transfers on a rising edge where m_axis_valid and
    // m_axis_ready are both high; the word is held unchanged until then.
    assign full         = (count == (AW + 1)'(FIFO_DEPTH));
    assign m_axis_valid = (count != '0);
    assign head_flag    = mem_flag[rd_ptr];
    assign pop          = m_axis_valid && m_axis_ready && (!head_flag || state_q == EMIT_DATA);
    assign accept       = s_axis_valid && m_axis_xfer_req && (!full || pop);
    assign drop         = s_axis_valid && m_axis_xfer_req && full && !pop;
    assign entry_flag   = (timestamp_every != 32'd0) && (blk_cnt_q == 32'd0);
    assign fsm_state    = (state_q == EMIT_DATA);

    always_comb begin
        m_axis_data = '0;
        if (m_axis_valid) begin
            if (head_flag && state_q == EMIT_TS) begin
                m_axis_data[63:0] = mem_ts[rd_ptr];
            end else begin
                m_axis_data = mem_data[rd_ptr];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!m_axis_xfer_req) begin
            state_d = EMIT_TS;
        end else if (m_axis_valid && m_axis_ready) begin
            if (state_q == EMIT_TS && head_flag) begin
                state_d = EMIT_DATA;
            end else begin
                state_d = EMIT_TS;
            end
        end
    end

    // A drop forces the counter to 0 so the next accepted block is re-timestamped.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (!m_axis_xfer_req || timestamp_every == 32'd0 || drop) begin
            blk_cnt_d = 32'd0;
        end else if (accept) begin
            if (blk_cnt_q >= timestamp_every - 32'd1) begin
                blk_cnt_d = 32'd0;
            end else begin
                blk_cnt_d = blk_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge adc_clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= EMIT_TS;
            blk_cnt_q <= 32'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
            overflow  <= drop;
            if (!m_axis_xfer_req) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({accept, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge adc_clk) begin
        if (accept) begin
            mem_data[wr_ptr] <= s_axis_data;
            mem_ts[wr_ptr]   <= timestamp;
            mem_flag[wr_ptr] <= entry_flag;
        end
    end

endmodule

// File: tb/tb_util_cpack2_timestamp_insert.sv
// Directed bench for util_cpack2_timestamp_insert: a reference model of the block
// counter fills an expected-word queue that is checked against every output word.
module tb_util_cpack2_timestamp_insert;

    localparam int NCH   = 4;
    localparam int SPC   = 2;
    localparam int SDW   = 16;
    localparam int DEPTH = 8;
    localparam int W     = NCH * SPC * SDW;

    logic          adc_clk;
    logic          resetn;
    logic [63:0]   timestamp;
    logic [31:0]   timestamp_every;
    logic          s_axis_valid;
    logic [W-1:0]  s_axis_data;
    logic          m_axis_xfer_req;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic [W-1:0]  m_axis_data;
    logic          overflow;
    logic          fsm_state;

    logic [W-1:0]  exp_q[$];
    logic          exp_ovf;
    int unsigned   mcnt;
    int            checks;
    int            errors;

    util_cpack2_timestamp_insert #(
        .NUM_OF_CHANNELS    (NCH),
        .SAMPLES_PER_CHANNEL(SPC),
        .SAMPLE_DATA_WIDTH  (SDW),
        .FIFO_DEPTH         (DEPTH)
    ) dut (
        .adc_clk        (adc_clk),
        .resetn         (resetn),
        .timestamp      (timestamp),
        .timestamp_every(timestamp_every),
        .s_axis_valid   (s_axis_valid),
        .s_axis_data    (s_axis_data),
        .m_axis_xfer_req(m_axis_xfer_req),
        .m_axis_valid   (m_axis_valid),
        .m_axis_ready   (m_axis_ready),
        .m_axis_data    (m_axis_data),
        .overflow       (overflow),
        .fsm_state      (fsm_state)
    );

    // clock / reset
    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ts_word(input logic [63:0] t);
        logic [W-1:0] r;
        r = '0;
        r[63:0] = t;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // reference model: predicted words for one accepted block
    task automatic exp_block(input logic [W-1:0] d);
        if (timestamp_every != 0 && mcnt == 0) exp_q.push_back(ts_word(timestamp));
        exp_q.push_back(d);
        if (timestamp_every == 0 || mcnt >= timestamp_every - 1) mcnt = 0;
        else mcnt = mcnt + 1;
    endtask

    // driver tasks
    task automatic tick();
        @(posedge adc_clk);
        #1;
        timestamp = timestamp + 64'd1;
    endtask

    task automatic idle(input int n);
        s_axis_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [W-1:0] d, input bit accepted);
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        if (accepted) exp_block(d);
        tick();
        s_axis_valid = 1'b0;
    endtask

    task automatic send_dropped(input logic [W-1:0] d);
        send(d, 1'b0);
        mcnt    = 0;
        exp_ovf = 1'b1;
        tick();
        exp_ovf = 1'b0;
    endtask

    task automatic drain(input string tag);
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
        chk({tag, "_drained"}, W'(exp_q.size()), '0);
        tick();
        chk({tag, "_idle_valid"}, W'(m_axis_valid), '0);
    endtask

    // scoreboard: every output word is compared with the queue head
    always @(negedge adc_clk) begin
        if (resetn) begin
            chk("overflow", W'(overflow), W'(exp_ovf));
            if (m_axis_valid) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_word got %h exp none", m_axis_data);
                end
                if (exp_q.size() != 0) begin
                    chk("out_word", m_axis_data, exp_q[0]);
                    if (m_axis_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [W-1:0] d;
        checks          = 0;
        errors          = 0;
        mcnt            = 0;
        exp_ovf         = 1'b0;
        resetn          = 1'b0;
        timestamp       = 64'd0;
        timestamp_every = 32'd4;
        s_axis_valid    = 1'b0;
        s_axis_data     = '0;
        m_axis_xfer_req = 1'b0;
        m_axis_ready    = 1'b0;

        // reset state
        repeat (3) @(posedge adc_clk);
        #1;
        chk("rst_valid", W'(m_axis_valid), '0);
        chk("rst_data", m_axis_data, '0);
        chk("rst_overflow", W'(overflow), '0);
        chk("rst_fsm", W'(fsm_state), '0);
        resetn = 1'b1;
        tick();

        // N=4, valid every 2nd cycle, first accept at ts 1000
        m_axis_xfer_req = 1'b1;
        m_axis_ready    = 1'b1;
        timestamp       = 64'd1000;
        for (int i = 0; i < 8; i++) begin
            send(64'hD0 + W'(i), 1'b1);
            idle(1);
        end
        drain("framing_n4");

        // N=0: pass-through, one-cycle latency, no timestamp words
        timestamp_every = 32'd0;
        for (int i = 0; i < 6; i++) begin
            d = rand_word();
            send(d, 1'b1);
            chk("latency_valid", W'(m_axis_valid), W'(1));
            chk("latency_data", m_axis_data, d);
        end
        drain("passthru");

        // N=4, ready low: 8 stored, 9th dropped, resync after draining
        timestamp_every = 32'd4;
        m_axis_ready    = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(rand_word(), 1'b1);
        send_dropped(rand_word());
        m_axis_ready = 1'b1;
        idle(3);
        send(rand_word(), 1'b1);
        drain("overflow_resync");

        // ready toggling while a flagged entry is at the head
        m_axis_ready = 1'b0;
        send(rand_word(), 1'b1);
        send(rand_word(), 1'b1);
        chk("stall_fsm", W'(fsm_state), '0);
        for (int i = 0; i < 8; i++) begin
            m_axis_ready = i[0];
            tick();
        end
        drain("ready_toggle");

        // full buffer with a pop in the same cycle keeps the count
        timestamp_every = 32'd0;
        mcnt            = 0;
        m_axis_ready    = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(rand_word(), 1'b1);
        m_axis_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(rand_word(), 1'b1);
        m_axis_ready = 1'b0;
        send_dropped(rand_word());
        drain("full_push_pop");

        // xfer_req dropped with 5 entries buffered
        timestamp_every = 32'd4;
        m_axis_ready    = 1'b0;
        for (int i = 0; i < 5; i++) send(rand_word(), 1'b1);
        m_axis_xfer_req = 1'b0;
        tick();
        exp_q.delete();
        mcnt = 0;
        chk("flush_valid", W'(m_axis_valid), '0);
        send(rand_word(), 1'b0);
        chk("discard_valid", W'(m_axis_valid), '0);
        m_axis_xfer_req = 1'b1;
        m_axis_ready    = 1'b1;
        d = rand_word();
        timestamp = 64'h1234_5678_9ABC_DEF0;
        send(d, 1'b1);
        chk("rearm_first_ts", m_axis_data, ts_word(64'h1234_5678_9ABC_DEF0));
        drain("rearm");

        // asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) send(rand_word(), 1'b1);
        s_axis_valid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", W'(m_axis_valid), '0);
        chk("async_rst_data", m_axis_data, '0);
        chk("async_rst_overflow", W'(overflow), '0);
        chk("async_rst_fsm", W'(fsm_state), '0);
        s_axis_valid = 1'b0;
        exp_q.delete();
        mcnt = 0;
        tick();
        resetn = 1'b1;
        tick();
        timestamp = 64'd5000;
        d = rand_word();
        send(d, 1'b1);
        chk("post_rst_first_ts", m_axis_data, ts_word(64'd5000));
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout got running exp finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
